// File: rtl/lms_fir_mc.sv
// Multi-channel adaptive LMS FIR: one sample shift per run, then a 5-stage
// per-tap pipeline that updates each weight and accumulates the filter output.
module lms_fir_mc #(
  parameter int TAPS    = 64,
  parameter int CH      = 2,
  parameter int DW      = 16,
  parameter int WW      = 26,
  parameter int LEAK_SH = 4,
  localparam int CHW    = (CH > 1) ? $clog2(CH) : 1,
  localparam int TW     = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHW-1:0]       ch_sel,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] err_in,
  input  logic [2:0]           mu_shift,
  input  logic                 leak_en,
  input  logic                 freeze,
  output logic signed [DW-1:0] out_sample,
  output logic                 out_valid,
  output logic                 busy,
  input  logic                 rd_en,
  input  logic [CHW-1:0]       rd_ch,
  input  logic [TW-1:0]        rd_tap,
  output logic [WW-1:0]        rd_data
);

  localparam int AW = 2*DW + TW + 1;
  localparam int SW = (2*DW > WW+2) ? 2*DW : WW+2;
  localparam logic [TW-1:0] LAST_TAP = TW'(TAPS-1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  function automatic logic signed [2*DW-1:0] smul(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] ae;
    logic signed [2*DW-1:0] be;
    ae = (2*DW)'(a);
    be = (2*DW)'(b);
    return ae * be;
  endfunction

  function automatic logic signed [WW-1:0] sat_ww(input logic signed [SW-1:0] v);
    if (&v[SW-1:WW-1] || ~|v[SW-1:WW-1]) return v[WW-1:0];
    else if (v[SW-1]) return {1'b1, {(WW-1){1'b0}}};
    else return {1'b0, {(WW-1){1'b1}}};
  endfunction

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
    if (&v[AW-1:DW-1] || ~|v[AW-1:DW-1]) return v[DW-1:0];
    else if (v[AW-1]) return {1'b1, {(DW-1){1'b0}}};
    else return {1'b0, {(DW-1){1'b1}}};
  endfunction

  state_e state_r, state_s;
  logic done_s, accept_s;

  logic [CHW-1:0]       ch_r;
  logic signed [DW-1:0] err_r;
  logic [2:0]           mu_r;
  logic                 leak_r, frz_r;
  logic [TW-1:0]        tap_cnt_r;

  logic signed [DW-1:0] hist_r [CH][TAPS];
  logic signed [WW-1:0] w_r    [CH][TAPS];
  logic signed [AW-1:0] acc_r, acc_nxt_s;

  logic                   op_v_r, op_last_r;
  logic [TW-1:0]          op_tap_r;
  logic signed [DW-1:0]   op_x_r;
  logic signed [WW-1:0]   op_w_r;
  logic                   p_v_r, p_last_r;
  logic [TW-1:0]          p_tap_r;
  logic signed [DW-1:0]   p_x_r;
  logic signed [WW-1:0]   p_w_r;
  logic signed [2*DW-1:0] p_r;
  logic                   b_v_r, b_last_r;
  logic signed [DW-1:0]   b_r, b_x_r;
  logic                   q_v_r, q_last_r;
  logic signed [2*DW-1:0] q_r;

  logic signed [SW-1:0] u_s, sum_s;
  logic signed [WW-1:0] l_s, w_new_s;

  logic signed [DW-1:0] out_sample_r;
  logic                 out_valid_r, busy_r;
  logic [WW-1:0]        rd_data_r;

  assign accept_s = (state_r == IDLE) && start;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // FSM next state; done fires when the last tap leaves the MAC stage
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE:  if (start) state_s = RUN; else state_s = IDLE;
      RUN:   if (tap_cnt_r == LAST_TAP) state_s = DRAIN; else state_s = RUN;
      DRAIN: begin
        if (q_v_r && q_last_r) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Run context captured on accept and held for the whole run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_r      <= '0;
      err_r     <= '0;
      mu_r      <= 3'd0;
      leak_r    <= 1'b0;
      frz_r     <= 1'b0;
      tap_cnt_r <= '0;
    end else if (accept_s) begin
      ch_r      <= ch_sel;
      err_r     <= err_in;
      mu_r      <= mu_shift;
      leak_r    <= leak_en;
      frz_r     <= freeze;
      tap_cnt_r <= '0;
    end else if (state_r == RUN) begin
      tap_cnt_r <= tap_cnt_r + TW'(1);
    end
  end

  // Sample history shift for the selected channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < TAPS; k++) hist_r[c][k] <= '0;
    end else if (accept_s) begin
      for (int k = TAPS-1; k > 0; k--) hist_r[ch_sel][k] <= hist_r[ch_sel][k-1];
      hist_r[ch_sel][0] <= x_in;
    end
  end

  // Weight update: floor-shifted gradient, optional leakage, saturate to WW
  always_comb begin
    u_s     = (SW'(p_r) >>> (DW-1)) >>> mu_r;
    l_s     = leak_r ? (p_w_r >>> LEAK_SH) : '0;
    sum_s   = SW'(p_w_r) - SW'(l_s) + u_s;
    w_new_s = frz_r ? p_w_r : sat_ww(sum_s);
  end

  // Weight bank write-back from the update stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < TAPS; k++) w_r[c][k] <= '0;
    end else if (p_v_r && !frz_r) begin
      w_r[ch_r][p_tap_r] <= w_new_s;
    end
  end

  // Tap pipeline: operand read, gradient product, update/B-operand, output product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_v_r <= 1'b0; op_last_r <= 1'b0; op_tap_r <= '0; op_x_r <= '0; op_w_r <= '0;
      p_v_r  <= 1'b0; p_last_r  <= 1'b0; p_tap_r  <= '0; p_x_r  <= '0; p_w_r  <= '0;
      p_r    <= '0;
      b_v_r  <= 1'b0; b_last_r  <= 1'b0; b_r <= '0; b_x_r <= '0;
      q_v_r  <= 1'b0; q_last_r  <= 1'b0; q_r <= '0;
    end else begin
      op_v_r    <= (state_r == RUN);
      op_last_r <= (tap_cnt_r == LAST_TAP);
      op_tap_r  <= tap_cnt_r;
      op_x_r    <= hist_r[ch_r][tap_cnt_r];
      op_w_r    <= w_r[ch_r][tap_cnt_r];
      p_v_r     <= op_v_r;
      p_last_r  <= op_last_r;
      p_tap_r   <= op_tap_r;
      p_x_r     <= op_x_r;
      p_w_r     <= op_w_r;
      p_r       <= smul(err_r, op_x_r);
      b_v_r     <= p_v_r;
      b_last_r  <= p_last_r;
      b_r       <= w_new_s[WW-1 -: DW];
      b_x_r     <= p_x_r;
      q_v_r     <= b_v_r;
      q_last_r  <= b_last_r;
      q_r       <= smul(b_r, b_x_r);
    end
  end

  // Final MAC term is folded in combinationally so completion lands at TAPS+5
  always_comb begin
    if (q_v_r) acc_nxt_s = acc_r + AW'(q_r);
    else       acc_nxt_s = acc_r;
  end

  // Accumulator: bias preload on accept, MAC otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        acc_r <= '0;
    else if (accept_s) acc_r <= AW'(a_in) <<< (DW-1);
    else               acc_r <= acc_nxt_s;
  end

  // Registered result, completion pulse and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sample_r <= '0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      out_valid_r <= done_s;
      if (done_s) out_sample_r <= sat_dw(acc_nxt_s >>> (DW-1));
      if (accept_s)    busy_r <= 1'b1;
      else if (done_s) busy_r <= 1'b0;
    end
  end

  // Weight readback; same-cycle writes are not forwarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data_r <= '0;
    else if (rd_en) rd_data_r <= w_r[rd_ch][rd_tap];
  end

  assign out_sample = out_sample_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign rd_data    = rd_data_r;

endmodule

// File: tb/tb_lms_fir_mc.sv
// Directed self-checking bench for lms_fir_mc with TAPS=4, CH=2.
module tb_lms_fir_mc;
  localparam int TAPS = 4, CH = 2, DW = 16, WW = 26, LEAK_SH = 4;
  localparam int LAT = TAPS + 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [0:0]           ch_sel;
  logic signed [DW-1:0] x_in, a_in, err_in;
  logic [2:0]           mu_shift;
  logic                 leak_en, freeze;
  logic signed [DW-1:0] out_sample;
  logic                 out_valid, busy;
  logic                 rd_en;
  logic [0:0]           rd_ch;
  logic [1:0]           rd_tap;
  logic [WW-1:0]        rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  lms_fir_mc #(.TAPS(TAPS), .CH(CH), .DW(DW), .WW(WW), .LEAK_SH(LEAK_SH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_sel(ch_sel), .x_in(x_in),
    .a_in(a_in), .err_in(err_in), .mu_shift(mu_shift), .leak_en(leak_en),
    .freeze(freeze), .out_sample(out_sample), .out_valid(out_valid), .busy(busy),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_tap(rd_tap), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One run from acceptance to completion; pulse re-asserts start on cycles 1..8
  task automatic run(input string tag, input int ch, input int x, input int a,
                     input int err, input int mu, input int leak, input int frz,
                     input int pulse, input int exp_out);
    int vcnt, vcyc, busy_bad;
    logic signed [DW-1:0] osamp;
    vcnt = 0; vcyc = -1; busy_bad = 0; osamp = '0;
    @(negedge clk);
    ch_sel = 1'(ch); x_in = 16'(x); a_in = 16'(a); err_in = 16'(err);
    mu_shift = 3'(mu); leak_en = 1'(leak); freeze = 1'(frz);
    start = 1'b1;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (busy !== (c < LAT)) busy_bad++;
      if (out_valid === 1'b1) begin
        vcnt++;
        vcyc  = c;
        osamp = out_sample;
      end
      start = (pulse != 0) && (c <= 8);
      if (start) begin
        x_in = -16'sd16384; err_in = 16'sd16384; a_in = -16'sd1; ch_sel = 1'b1;
      end
    end
    start = 1'b0;
    chk({tag, "_nvalid"}, vcnt, 1);
    chk({tag, "_vcycle"}, vcyc, LAT);
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_out"}, osamp, exp_out);
  endtask

  task automatic rb(input string tag, input int ch, input int tap, input int exp);
    @(negedge clk);
    rd_en = 1'b1; rd_ch = 1'(ch); rd_tap = 2'(tap);
    @(negedge clk);
    rd_en = 1'b0;
    chk(tag, $signed(rd_data), exp);
  endtask

  initial begin
    int vcnt;
    rst_n = 1'b0; start = 1'b0; ch_sel = 1'b0; x_in = '0; a_in = '0; err_in = '0;
    mu_shift = 3'd0; leak_en = 1'b0; freeze = 1'b0; rd_en = 1'b0; rd_ch = 1'b0; rd_tap = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_out", out_sample, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_rd", $signed(rd_data), 0);
    rst_n = 1'b1;

    // Learning, channel isolation, leakage, saturation
    run("learn", 0, 16384, 0, 16384, 0, 0, 0, 0, 4);
    rb("learn_w0", 0, 0, 8192);
    run("iso", 1, 1000, 7, 0, 0, 0, 0, 0, 7);
    rb("iso_ch1w0", 1, 0, 0);
    rb("iso_ch0w0", 0, 0, 8192);
    run("leak", 0, 16384, 0, 0, 0, 1, 0, 0, 3);
    rb("leak_w0", 0, 0, 7680);
    run("satp", 0, 16384, 32767, 0, 0, 0, 0, 0, 32767);
    run("satn", 0, -16384, -32768, 0, 0, 0, 0, 0, -32768);
    rb("sat_w0", 0, 0, 7680);

    // Reset in the middle of a run
    @(negedge clk);
    ch_sel = 1'b0; x_in = 16'sd16384; err_in = 16'sd16384; a_in = 16'sd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_out", out_sample, 0);
    vcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) vcnt++;
    end
    chk("mrst_novalid", vcnt, 0);
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TAPS; k++) rb("mrst_w", c, k, 0);

    // Bias passthrough and latency
    run("bias", 0, 1000, 100, 0, 0, 0, 0, 0, 100);

    // Step size
    do_reset();
    run("mu3", 0, 16384, 0, 16384, 3, 0, 0, 0, 0);
    rb("mu3_w0", 0, 0, 1024);

    // Freeze
    do_reset();
    run("frz", 0, 16384, 55, 16384, 0, 0, 1, 0, 55);
    rb("frz_w0", 0, 0, 0);

    // Starts while busy are ignored; start on cycle 10 is accepted
    do_reset();
    run("bsyA", 0, 16384, 0, 0, 0, 0, 0, 0, 0);
    run("bsyB", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    run("bsyC", 0, 0, 0, 16384, 0, 0, 0, 0, 4);
    rb("bsy_w0", 0, 0, 0);
    rb("bsy_w1", 0, 1, 0);
    rb("bsy_w2", 0, 2, 8192);
    rb("bsy_w3", 0, 3, 0);
    rb("bsy_ch1w0", 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
